// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the exception/ERET commit sequencer: exception codes,
// handler vector, FSM states, the capture record and small decode helpers.
package exc_commit_ctrl_pkg;

  typedef enum logic [4:0] {
    EXC_NONE = 5'h00,
    EXC_INT  = 5'h01,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c,
    EXC_ERET = 5'h0e
  } exc_code_e;

  localparam logic [31:0] EXC_HANDLER_VEC = 32'hbfc0_0380;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  typedef struct packed {
    logic [31:0] exc_type;
    logic [31:0] pc_new;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] bad_vaddr;
  } exc_cap_t;

  // Full 32-bit match so that unknown wide codes never alias a known one.
  function automatic logic type_is(input logic [31:0] t, input exc_code_e c);
    return t == {27'd0, c};
  endfunction

  function automatic logic [4:0] exccode_of(input logic [31:0] t);
    return type_is(t, EXC_INT) ? 5'h00 : t[4:0];
  endfunction

  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/exc_capture_reg.sv
// Capture bank for the exception record. Exposes the next-state value so the
// commit decode can use the record in the same cycle it is loaded.
module exc_capture_reg
  import exc_commit_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  exc_cap_t cap_i,
  output exc_cap_t cap_next_o
);

  exc_cap_t cap_q;
  exc_cap_t cap_d;

  always_comb begin
    cap_d = cap_q;
    if (load_i) begin
      cap_d = cap_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign cap_next_o = cap_d;

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/ERET commit sequencer in MEM: waits out bus stalls, then issues one
// atomic flush + CP0 update + PC redirect. Optional counters: EXC_STATS_EN.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'hbfc0_0000,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        longest_stall,
  input  logic [31:0] exc_type_M,
  input  logic [31:0] pc_new_M,
  input  logic [31:0] pc_M,
  input  logic        in_delay_slot_M,
  input  logic [31:0] bad_vaddr_M,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        cp0_exc_we,
  output logic        cp0_eret,
  output logic [31:0] cp0_epc_o,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_bd,
  output logic        cp0_badvaddr_we,
  output logic [31:0] cp0_badvaddr,
  output logic        busy
`ifdef EXC_STATS_EN
  ,
  output logic [31:0] exc_count,
  output logic [31:0] eret_count
`endif
);

  localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic        in_reset_q;
  logic [1:0]  hold_cnt_q, hold_cnt_d;
  logic        cap_load;
  exc_cap_t    cap_in;
  exc_cap_t    cap_next;

  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        exc_we_q, exc_we_d;
  logic        eret_q, eret_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        bd_q, bd_d;
  logic        badvaddr_we_q, badvaddr_we_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  always_comb begin
    cap_in           = '0;
    cap_in.exc_type  = exc_type_M;
    cap_in.pc_new    = pc_new_M;
    cap_in.pc        = pc_M;
    cap_in.bd        = in_delay_slot_M;
    cap_in.bad_vaddr = bad_vaddr_M;
  end

  exc_capture_reg u_capture (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cap_load),
    .cap_i      (cap_in),
    .cap_next_o (cap_next)
  );

  // BOOT spans the reset window plus exactly one cycle after release.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cap_load   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (!in_reset_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (exc_type_M != 32'd0) begin
          cap_load = 1'b1;
          state_d  = longest_stall ? ST_WAIT : ST_COMMIT;
        end
      end
      ST_WAIT: begin
        if (!longest_stall) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d    = ST_HOLD;
        hold_cnt_d = 2'd0;
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 2'd1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Outputs are decoded from the next state so a commit lands one cycle after detection.
  always_comb begin
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    exc_we_d         = 1'b0;
    eret_d           = 1'b0;
    epc_d            = epc_q;
    exccode_d        = exccode_q;
    bd_d             = bd_q;
    badvaddr_we_d    = 1'b0;
    badvaddr_d       = badvaddr_q;
    case (state_d)
      ST_BOOT: begin
        flush_d          = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = RESET_PC;
      end
      ST_COMMIT: begin
        flush_d          = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = cap_next.pc_new;
        if (type_is(cap_next.exc_type, EXC_ERET)) begin
          eret_d = 1'b1;
        end else begin
          exc_we_d  = 1'b1;
          exccode_d = exccode_of(cap_next.exc_type);
          bd_d      = cap_next.bd;
          epc_d     = epc_of(cap_next.pc, cap_next.bd);
          if (type_is(cap_next.exc_type, EXC_ADEL) || type_is(cap_next.exc_type, EXC_ADES)) begin
            badvaddr_we_d = 1'b1;
            badvaddr_d    = cap_next.bad_vaddr;
          end
        end
      end
      ST_HOLD: begin
        flush_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_BOOT;
      in_reset_q       <= 1'b1;
      hold_cnt_q       <= 2'd0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= RESET_PC;
      exc_we_q         <= 1'b0;
      eret_q           <= 1'b0;
      epc_q            <= 32'd0;
      exccode_q        <= 5'd0;
      bd_q             <= 1'b0;
      badvaddr_we_q    <= 1'b0;
      badvaddr_q       <= 32'd0;
    end else begin
      state_q          <= state_d;
      in_reset_q       <= 1'b0;
      hold_cnt_q       <= hold_cnt_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      exc_we_q         <= exc_we_d;
      eret_q           <= eret_d;
      epc_q            <= epc_d;
      exccode_q        <= exccode_d;
      bd_q             <= bd_d;
      badvaddr_we_q    <= badvaddr_we_d;
      badvaddr_q       <= badvaddr_d;
    end
  end

  assign flush_all       = flush_q;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_pc     = redirect_pc_q;
  assign cp0_exc_we      = exc_we_q;
  assign cp0_eret        = eret_q;
  assign cp0_epc_o       = epc_q;
  assign cp0_exccode     = exccode_q;
  assign cp0_bd          = bd_q;
  assign cp0_badvaddr_we = badvaddr_we_q;
  assign cp0_badvaddr    = badvaddr_q;
  assign busy            = (state_q != ST_IDLE);

`ifdef EXC_STATS_EN
  logic [31:0] exc_count_q;
  logic [31:0] eret_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count_q  <= 32'd0;
      eret_count_q <= 32'd0;
    end else begin
      if (exc_we_d) begin
        exc_count_q <= exc_count_q + 32'd1;
      end
      if (eret_d) begin
        eret_count_q <= eret_count_q + 32'd1;
      end
    end
  end

  assign exc_count  = exc_count_q;
  assign eret_count = eret_count_q;
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: a cycle-indexed reference model of
// the commit timing rules, compared every cycle, plus literal spot checks.
module tb_exc_commit_ctrl;
  import exc_commit_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
  localparam int          HOLD     = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        longest_stall = 1'b0;
  logic [31:0] exc_type_M = 32'd0;
  logic [31:0] pc_new_M = 32'd0;
  logic [31:0] pc_M = 32'd0;
  logic        in_delay_slot_M = 1'b0;
  logic [31:0] bad_vaddr_M = 32'd0;

  logic        flush_all, redirect_valid, cp0_exc_we, cp0_eret, cp0_bd, cp0_badvaddr_we, busy;
  logic [31:0] redirect_pc, cp0_epc_o, cp0_badvaddr;
  logic [4:0]  cp0_exccode;
`ifdef EXC_STATS_EN
  logic [31:0] exc_count, eret_count;
`endif

  always #5 clk = ~clk;

  exc_commit_ctrl #(.RESET_PC(RESET_PC), .HOLD_CYCLES(HOLD)) dut (
    .clk             (clk),
    .rst             (rst),
    .longest_stall   (longest_stall),
    .exc_type_M      (exc_type_M),
    .pc_new_M        (pc_new_M),
    .pc_M            (pc_M),
    .in_delay_slot_M (in_delay_slot_M),
    .bad_vaddr_M     (bad_vaddr_M),
    .flush_all       (flush_all),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .cp0_exc_we      (cp0_exc_we),
    .cp0_eret        (cp0_eret),
    .cp0_epc_o       (cp0_epc_o),
    .cp0_exccode     (cp0_exccode),
    .cp0_bd          (cp0_bd),
    .cp0_badvaddr_we (cp0_badvaddr_we),
    .cp0_badvaddr    (cp0_badvaddr),
    .busy            (busy)
`ifdef EXC_STATS_EN
    ,
    .exc_count       (exc_count),
    .eret_count      (eret_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: an exception accepted in cycle t commits in the cycle after
  // the first cycle >= t with the stall low; HOLD flush cycles follow.
  longint      cyc_n = 0;
  longint      accept_from = 64'sh7fff_ffff_ffff_ffff;
  longint      hold_last = -1;
  bit          boot_due = 1'b0;
  bit          pend_v = 1'b0;
  bit          model_ok = 1'b0;
  logic [31:0] p_type, p_pcnew, p_pc, p_bva;
  logic        p_bd;
  logic        e_flush, e_rv, e_we, e_eret, e_bwe, e_busy, e_rst, e_bd;
  logic [31:0] e_rpc, e_epc, e_bva;
  logic [4:0]  e_code;
  int unsigned e_exc_cnt = 0, e_eret_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      e_flush = 1'b0; e_rv = 1'b0; e_we = 1'b0; e_eret = 1'b0;
      e_bwe = 1'b0; e_busy = 1'b0; e_rst = 1'b0;
      if (rst) begin
        pend_v = 1'b0; boot_due = 1'b1; hold_last = -1;
        accept_from = 64'sh7fff_ffff_ffff_ffff;
        e_busy = 1'b1; e_rst = 1'b1;
        e_exc_cnt = 0; e_eret_cnt = 0;
      end else if (boot_due) begin
        boot_due = 1'b0;
        e_flush = 1'b1; e_rv = 1'b1; e_rpc = RESET_PC; e_busy = 1'b1;
        accept_from = cyc_n + 2;
      end else begin
        if (!pend_v && cyc_n >= accept_from && exc_type_M != 32'd0) begin
          pend_v = 1'b1;
          p_type = exc_type_M; p_pcnew = pc_new_M; p_pc = pc_M;
          p_bd = in_delay_slot_M; p_bva = bad_vaddr_M;
        end
        if (pend_v && !longest_stall) begin
          pend_v = 1'b0;
          e_flush = 1'b1; e_rv = 1'b1; e_rpc = p_pcnew; e_busy = 1'b1;
          if (p_type == 32'h0e) begin
            e_eret = 1'b1; e_eret_cnt++;
          end else begin
            e_we = 1'b1; e_exc_cnt++;
            e_code = (p_type == 32'h01) ? 5'h00 : p_type[4:0];
            e_bd = p_bd;
            e_epc = p_bd ? p_pc - 32'd4 : p_pc;
            if (p_type == 32'h04 || p_type == 32'h05) begin
              e_bwe = 1'b1; e_bva = p_bva;
            end
          end
          hold_last = cyc_n + 1 + HOLD;
          accept_from = cyc_n + 2 + HOLD;
        end else if (cyc_n + 1 <= hold_last) begin
          e_flush = 1'b1; e_busy = 1'b1;
        end
        if (pend_v) e_busy = 1'b1;
      end
      cyc_n++;
      model_ok = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("flush_all", 32'(flush_all), 32'(e_flush));
        chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        chk("cp0_exc_we", 32'(cp0_exc_we), 32'(e_we));
        chk("cp0_eret", 32'(cp0_eret), 32'(e_eret));
        chk("cp0_badvaddr_we", 32'(cp0_badvaddr_we), 32'(e_bwe));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
        if (e_we) begin
          chk("cp0_exccode", 32'(cp0_exccode), 32'(e_code));
          chk("cp0_bd", 32'(cp0_bd), 32'(e_bd));
          chk("cp0_epc_o", cp0_epc_o, e_epc);
        end
        if (e_bwe) chk("cp0_badvaddr", cp0_badvaddr, e_bva);
        if (e_rst) begin
          chk("rst_redirect_pc", redirect_pc, RESET_PC);
          chk("rst_epc", cp0_epc_o, 32'd0);
          chk("rst_badvaddr", cp0_badvaddr, 32'd0);
          chk("rst_exccode", 32'(cp0_exccode), 32'd0);
        end
`ifdef EXC_STATS_EN
        chk("exc_count", exc_count, e_exc_cnt);
        chk("eret_count", eret_count, e_eret_cnt);
`endif
      end
    end
  end

  // Drive one cycle of inputs at a negedge and return at the following negedge.
  task automatic cyc(input logic r, input logic [31:0] t, input logic [31:0] pn,
                     input logic [31:0] p, input logic bd, input logic [31:0] bva,
                     input logic st);
    rst = r; exc_type_M = t; pc_new_M = pn; pc_M = p;
    in_delay_slot_M = bd; bad_vaddr_M = bva; longest_stall = st;
    @(negedge clk);
    $display("cyc rst=%0d type=%h pc=%h bd=%0d stall=%0d -> flush=%0d rv=%0d rpc=%h we=%0d eret=%0d code=%h epc=%h bwe=%0d bva=%h busy=%0d",
             r, t, p, bd, st, flush_all, redirect_valid, redirect_pc, cp0_exc_we,
             cp0_eret, cp0_exccode, cp0_epc_o, cp0_badvaddr_we, cp0_badvaddr, busy);
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("lit_rst_rpc", redirect_pc, 32'hbfc0_0000);
    chk("lit_rst_flush", 32'(flush_all), 32'd0);
    chk("lit_rst_busy", 32'(busy), 32'd1);

    idle();
    chk("lit_boot_flush", 32'(flush_all), 32'd1);
    chk("lit_boot_rv", 32'(redirect_valid), 32'd1);
    chk("lit_boot_rpc", redirect_pc, 32'hbfc0_0000);
    idle();
    chk("lit_idle_rv", 32'(redirect_valid), 32'd0);
    chk("lit_idle_busy", 32'(busy), 32'd0);

    // Syscall, unstalled.
    cyc(1'b0, 32'h08, EXC_HANDLER_VEC, 32'h8000_0100, 1'b0, 32'd0, 1'b0);
    chk("lit_sys_we", 32'(cp0_exc_we), 32'd1);
    chk("lit_sys_code", 32'(cp0_exccode), 32'h08);
    chk("lit_sys_epc", cp0_epc_o, 32'h8000_0100);
    chk("lit_sys_rpc", redirect_pc, 32'hbfc0_0380);
    idle();
    chk("lit_sys_hold_flush", 32'(flush_all), 32'd1);
    chk("lit_sys_hold_we", 32'(cp0_exc_we), 32'd0);
    idle();

    // AdEL in delay slot behind a 5-cycle stall; junk on the inputs while waiting.
    cyc(1'b0, 32'h04, EXC_HANDLER_VEC, 32'h8000_0204, 1'b1, 32'h8000_0003, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0c, 32'h1234_5678, 32'h5555_0000, 1'b0, 32'h9999_9999, 1'b1);
      chk("lit_wait_we", 32'(cp0_exc_we), 32'd0);
    end
    cyc(1'b0, 32'h0c, 32'h1234_5678, 32'h5555_0000, 1'b0, 32'h9999_9999, 1'b0);
    chk("lit_adel_epc", cp0_epc_o, 32'h8000_0200);
    chk("lit_adel_bd", 32'(cp0_bd), 32'd1);
    chk("lit_adel_bwe", 32'(cp0_badvaddr_we), 32'd1);
    chk("lit_adel_bva", cp0_badvaddr, 32'h8000_0003);
    idle(); idle();

    // ERET.
    cyc(1'b0, 32'h0e, 32'h8000_0400, 32'h8000_0300, 1'b0, 32'd0, 1'b0);
    chk("lit_eret", 32'(cp0_eret), 32'd1);
    chk("lit_eret_we", 32'(cp0_exc_we), 32'd0);
    chk("lit_eret_rpc", redirect_pc, 32'h8000_0400);
    idle(); idle();

    // Overflow held through COMMIT and HOLD, stall rising in COMMIT, then back-to-back BP.
    cyc(1'b0, 32'h0c, EXC_HANDLER_VEC, 32'h8000_0500, 1'b0, 32'd0, 1'b0);
    chk("lit_ov_code", 32'(cp0_exccode), 32'h0c);
    cyc(1'b0, 32'h0c, EXC_HANDLER_VEC, 32'h8000_0500, 1'b0, 32'd0, 1'b1);
    chk("lit_ov_hold_we", 32'(cp0_exc_we), 32'd0);
    cyc(1'b0, 32'h0c, EXC_HANDLER_VEC, 32'h8000_0500, 1'b0, 32'd0, 1'b0);
    chk("lit_ov_once", 32'(cp0_exc_we), 32'd0);
    cyc(1'b0, 32'h09, EXC_HANDLER_VEC, 32'h8000_0600, 1'b1, 32'd0, 1'b0);
    chk("lit_bp_code", 32'(cp0_exccode), 32'h09);
    chk("lit_bp_epc", cp0_epc_o, 32'h8000_05fc);
    idle(); idle();

    // Interrupt, unknown code, AdES.
    cyc(1'b0, 32'h01, EXC_HANDLER_VEC, 32'h8000_0700, 1'b0, 32'd0, 1'b0);
    chk("lit_int_code", 32'(cp0_exccode), 32'h00);
    idle(); idle();
    cyc(1'b0, 32'h0000_01f3, EXC_HANDLER_VEC, 32'h8000_0800, 1'b0, 32'd0, 1'b0);
    chk("lit_unk_code", 32'(cp0_exccode), 32'h13);
    chk("lit_unk_eret", 32'(cp0_eret), 32'd0);
    idle(); idle();
    cyc(1'b0, 32'h05, EXC_HANDLER_VEC, 32'h8000_0900, 1'b0, 32'h8000_0901, 1'b0);
    chk("lit_ades_bva", cp0_badvaddr, 32'h8000_0901);
    idle(); idle();

    // Reset while waiting on a stall: commit abandoned, boot pulse follows.
    cyc(1'b0, 32'h0c, EXC_HANDLER_VEC, 32'h8000_0a00, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk("lit_rstw_we", 32'(cp0_exc_we), 32'd0);
    chk("lit_rstw_busy", 32'(busy), 32'd1);
    idle();
    chk("lit_rstw_boot_rpc", redirect_pc, 32'hbfc0_0000);
    chk("lit_rstw_boot_we", 32'(cp0_exc_we), 32'd0);
    idle();

`ifdef EXC_STATS_EN
    cyc(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h08, EXC_HANDLER_VEC, 32'h8000_1000, 1'b0, 32'd0, 1'b0);
      idle(); idle();
    end
    cyc(1'b0, 32'h0e, 32'h8000_1004, 32'h8000_2000, 1'b0, 32'd0, 1'b0);
    idle(); idle();
    chk("lit_exc_count", exc_count, 32'd3);
    chk("lit_eret_count", eret_count, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Sequences exception/ERET commit in MEM stage: takes prioritised exception_type/pc_new from the exception unit and orchestrates the flush.
- Waits out memory-bus stalls (longest_stall), then issues one atomic commit: pipeline flush, CP0 EPC/Cause/Status/BadVAddr update, PC redirect.
- Sits between the exception unit, CP0 and hazard unit; sole owner of flush/redirect for exceptions.

Parameters:
- RESET_PC, 32'hbfc0_0000, PC redirect value forced for 1 cycle after reset release (boot).
- HOLD_CYCLES, 1, extra flush cycles after commit to kill wrong-path fetch (1..3).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- longest_stall  in  1  memory/bus stall; pipeline frozen while high
- exc_type_M  in  32  exception code from exception unit (0 = none)
- pc_new_M  in  32  handler / EPC target from exception unit
- pc_M  in  32  PC of MEM-stage instruction
- in_delay_slot_M  in  1  MEM instruction is in branch delay slot
- bad_vaddr_M  in  32  faulting address for AdEL/AdES
- flush_all  out  1  flush F/D/E/M/W pipeline registers
- redirect_valid  out  1  PC mux select for redirect
- redirect_pc  out  32  redirect target
- cp0_exc_we  out  1  CP0 exception-update strobe (EPC, Cause.ExcCode/BD, Status.EXL set)
- cp0_eret  out  1  CP0 Status.EXL clear strobe
- cp0_epc_o  out  32  EPC value to write
- cp0_exccode  out  5  Cause.ExcCode
- cp0_bd  out  1  Cause.BD
- cp0_badvaddr_we  out  1  BadVAddr write strobe
- cp0_badvaddr  out  32  BadVAddr value
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state=BOOT; all strobes 0, data outputs 0, redirect_pc=RESET_PC; reset mid-operation aborts any pending commit, nothing written to CP0.
- States: BOOT, IDLE, WAIT, COMMIT, HOLD.
- BOOT: redirect_valid=1, redirect_pc=RESET_PC, flush_all=1 for exactly 1 cycle -> IDLE.
- IDLE: if exc_type_M!=0, latch exc_type, pc_new, pc_M, in_delay_slot_M, bad_vaddr_M into capture regs. Then -> WAIT if longest_stall=1, else -> COMMIT. No outputs asserted in IDLE.
- WAIT: hold captured values (inputs ignored); -> COMMIT on first cycle longest_stall=0.
- COMMIT (1 cycle, registered outputs, latency 1 cycle from detection when unstalled):
  - flush_all=1, redirect_valid=1, redirect_pc=captured pc_new.
  - For type 0x0e (ERET): cp0_eret=1; cp0_exc_we=0.
  - Otherwise: cp0_exc_we=1; cp0_exccode = 5'h00 for type 0x01 (interrupt), else type[4:0].
  - cp0_bd=captured delay-slot flag; cp0_epc_o = pc-4 if BD else pc.
  - Types 0x04/0x05: cp0_badvaddr_we=1, cp0_badvaddr=captured bad_vaddr.
  - -> HOLD.
- HOLD: flush_all=1, all other strobes 0, exc_type_M ignored (wrong-path); after HOLD_CYCLES cycles -> IDLE.
- longest_stall rising during COMMIT: no effect; commit is atomic, CP0 writes are not stall-gated.
- Back-to-back: new exception accepted only after returning to IDLE; exception arriving on the IDLE cycle right after HOLD is accepted normally.
- Unknown nonzero type: treated as non-ERET, ExcCode=type[4:0].
- Strobes are single-cycle pulses; never assert cp0_exc_we and cp0_eret together.

Optional Feature:
- EXC_STATS_EN: adds outputs exc_count (32) and eret_count (32); exc_count increments on each COMMIT with cp0_exc_we, eret_count on each cp0_eret. Both clear on rst and wrap at 2^32-1 -> 0.
- Without the macro: ports and counters are absent.

Decomposition:
- Shared package/header: exception-type constants (INT 0x01, ADEL 0x04, ADES 0x05, SYS 0x08, BP 0x09, RI 0x0a, OV 0x0c, ERET 0x0e), handler vector 32'hbfc0_0380, FSM state encodings.
- Sub-module exc_capture_reg: capture register bank with load enable. Kept separate to isolate the WAIT-hold logic.

Test Plan:
- Reset release -> 1 cycle redirect_valid=1, redirect_pc=32'hbfc0_0000, flush_all=1; then IDLE with all strobes 0.
- exc_type_M=0x08, pc_M=0x8000_0100, BD=0, no stall -> next cycle cp0_exc_we=1, exccode=8, epc=0x8000_0100, redirect_pc=0xbfc0_0380; then 1 HOLD flush cycle.
- exc_type_M=0x04, BD=1, pc_M=0x8000_0204, bad_vaddr=0x8000_0003, longest_stall high 5 cycles -> no strobes for 5 cycles; then epc=0x8000_0200, bd=1, badvaddr_we=1 with 0x8000_0003.
- exc_type_M=0x0e, pc_new_M=0x8000_0400 -> cp0_eret=1, cp0_exc_we=0, redirect_pc=0x8000_0400.
- exc_type_M=0x0c held through COMMIT and HOLD -> exactly one commit; rst asserted in WAIT -> no CP0 write, state BOOT.
- With EXC_STATS_EN: 3 syscalls + 1 ERET -> exc_count=3, eret_count=1.
